// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (sync, 16-bit word count,
// little-endian data words, 8-bit checksum) and writes it into sequential word addresses.
module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    // Word index must be able to reach the full capacity, which is one bit wider than the
    // word-address field itself.
    localparam int          WIDX_W    = ADDR_W - 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << (ADDR_W - 2);

    typedef enum logic [2:0] {
        IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        len_lo;
    logic [WIDX_W-1:0] len_words;
    logic [WIDX_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [7:0]        csum;

    logic              accept;
    logic              clear;
    logic              word_last;
    logic [15:0]       n_rx;

    assign accept    = in_valid && in_ready;
    assign n_rx      = {in_data, len_lo};
    assign word_last = (word_idx + WIDX_W'(1)) == len_words;
    assign clear     = start && (state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                core_hold = 1'b0;
                if (start) state_nxt = SYNC;
            end
            SYNC: begin
                in_ready = 1'b1;
                if (accept && in_data == SYNC_BYTE) state_nxt = LEN0;
            end
            LEN0: begin
                in_ready = 1'b1;
                if (accept) state_nxt = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (n_rx == 16'd0)
                        state_nxt = CSUM;
                    else if ({1'b0, n_rx} > MAX_WORDS)
                        state_nxt = ERR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (accept && byte_cnt == 2'd3 && word_last) state_nxt = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (in_data == csum) ? DONE : ERR;
            end
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (start) state_nxt = SYNC;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = SYNC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte packing and the write pulse; the write launches one cycle after the 4th byte
    // independently of state, so a write pending on entry to CSUM still completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            len_lo     <= '0;
            len_words  <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            csum       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (clear) begin
                word_idx <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end
            if (state == LEN0 && accept) len_lo <= in_data;
            if (state == LEN1 && accept) len_words <= n_rx[WIDX_W-1:0];
            if (state == DATA && accept) begin
                csum     <= csum + in_data;
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= {in_data, word_buf[23:8]};
                if (byte_cnt == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
                    imem_wdata <= {in_data, word_buf};
                    word_idx   <= word_idx + WIDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a frame-level model predicts writes and outcome; a monitor
// checks every write pulse against the model's queue.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    int errors = 0;
    int checks = 0;
    int writes_seen = 0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: parse the byte list the way the protocol defines it and queue the
    // writes it implies. outcome: 0 = frame incomplete, 1 = good, 2 = failed.
    task automatic model_frame(input bq_t b, output int outcome);
        int i;
        int n;
        int sum;
        logic [31:0] w;
        outcome = 0;
        sum = 0;
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        i++;
        if (i + 2 > b.size()) return;
        n = b[i] + 256 * b[i+1];
        i += 2;
        if (n > (1 << (ADDR_W - 2))) begin
            outcome = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > b.size()) return;
            w = {b[i+3], b[i+2], b[i+1], b[i]};
            sum += b[i] + b[i+1] + b[i+2] + b[i+3];
            exp_addr_q.push_back(ADDR_W'(k * 4));
            exp_data_q.push_back(w);
            i += 4;
        end
        if (i >= b.size()) return;
        outcome = (b[i] == 8'(sum % 256)) ? 1 : 2;
    endtask

    always @(negedge clk) begin
        if (!rst && imem_we) begin
            writes_seen++;
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", imem_we, 1'b0);
            end else begin
                check("wr_addr", imem_addr, exp_addr_q.pop_front());
                check("wr_data", imem_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send(input bq_t b, input bit gaps);
        int t;
        for (int i = 0; i < b.size(); i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = b[i];
            t = 0;
            while (!in_ready && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) begin
                check("ready_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string nm, input bq_t b, input bit gaps);
        int outcome;
        model_frame(b, outcome);
        pulse_start;
        check({nm, "_hold_during_load"}, core_hold, 1'b1);
        send(b, gaps);
        repeat (3) @(negedge clk);
        check({nm, "_done"}, done, outcome == 1);
        check({nm, "_error"}, error, outcome == 2);
        check({nm, "_core_hold"}, core_hold, outcome != 1);
        check({nm, "_in_ready"}, in_ready, 1'b0);
        check({nm, "_writes_left"}, exp_addr_q.size(), 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_we"}, imem_we, 1'b0);
        check({nm, "_addr"}, imem_addr, 0);
        check({nm, "_wdata"}, imem_wdata, 0);
        check({nm, "_hold"}, core_hold, 1'b0);
        check({nm, "_ready"}, in_ready, 1'b0);
        check({nm, "_done"}, done, 1'b0);
        check({nm, "_error"}, error, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f1, f_bad, f_hunt, f_empty, f_empty_bad, f_over, f_part;
        int oc;
        int w_before;

        f1          = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                        8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        f_bad       = f1;
        f_bad[11]   = 8'h4D;
        f_hunt      = '{8'h00, 8'hFF, 8'h5A};
        foreach (f1[i]) f_hunt.push_back(f1[i]);
        f_empty     = '{8'hA5, 8'h00, 8'h00, 8'h00};
        f_empty_bad = '{8'hA5, 8'h00, 8'h00, 8'h01};
        f_over      = '{8'hA5, 8'h01, 8'h01};
        f_part      = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pin the model with hand-computed values before trusting it.
        model_frame(f1, oc);
        check("pin_outcome", oc, 1);
        check("pin_n", exp_data_q.size(), 2);
        check("pin_w0", exp_data_q[0], 32'h12345678);
        check("pin_w1", exp_data_q[1], 32'hDEADBEEF);
        check("pin_a1", exp_addr_q[1], 10'h004);
        exp_addr_q.delete();
        exp_data_q.delete();
        model_frame(f_bad, oc);
        check("pin_bad_outcome", oc, 2);
        exp_addr_q.delete();
        exp_data_q.delete();

        w_before = writes_seen;
        run_frame("good", f1, 1'b0);
        check("good_write_count", writes_seen - w_before, 2);
        check("good_addr_held", imem_addr, 10'h004);
        check("good_wdata_held", imem_wdata, 32'hDEADBEEF);

        w_before = writes_seen;
        run_frame("badsum", f_bad, 1'b0);
        check("badsum_write_count", writes_seen - w_before, 2);

        run_frame("hunt", f_hunt, 1'b0);

        w_before = writes_seen;
        run_frame("empty", f_empty, 1'b0);
        run_frame("empty_bad", f_empty_bad, 1'b0);
        check("empty_write_count", writes_seen - w_before, 0);

        w_before = writes_seen;
        run_frame("oversize", f_over, 1'b0);
        check("oversize_write_count", writes_seen - w_before, 0);
        run_frame("after_err", f1, 1'b0);

        // Abort mid-word: two data bytes of the first word accepted, then reset.
        w_before = writes_seen;
        pulse_start;
        send(f_part, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_write_count", writes_seen - w_before, 0);
        check("midreset_idle_ready", in_ready, 1'b0);

        w_before = writes_seen;
        run_frame("gaps", f1, 1'b1);
        check("gaps_write_count", writes_seen - w_before, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
